// File: rtl/image_capture_writer.sv
// Crops a BLK*OUT_DIM square from a grey pixel stream, box-averages each BLKxBLK block
// and writes the OUT_DIM x OUT_DIM result into image_mem, one strobe per output pixel.
module image_capture_writer #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int X_OFF   = 96,
    parameter int Y_OFF   = 16,
    parameter int BLK     = 16,   // power of 2, at least 2
    parameter int OUT_DIM = 28,
    parameter int INVERT  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pix_vld,
    input  logic       pix_sof,
    input  logic [7:0] pix_data,
    output logic       mem_we,
    output logic [9:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done
);

    localparam int LB    = $clog2(BLK);
    localparam int ACC_W = 8 + 2 * LB;
    localparam int CW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1;
    localparam int BXW   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [CW-1:0] X_OFF_C  = CW'(X_OFF);
    localparam logic [CW-1:0] Y_OFF_C  = CW'(Y_OFF);
    localparam logic [CW-1:0] WIN_C    = CW'(BLK * OUT_DIM);
    localparam logic [CW-1:0] X_LAST_C = CW'(IMG_W - 1);
    localparam logic [9:0]    DIM_C    = 10'(OUT_DIM);
    localparam logic [9:0]    LAST_C   = 10'(OUT_DIM * OUT_DIM - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]    x_reg, y_reg;
    logic [ACC_W-1:0] acc_reg [OUT_DIM];
    logic             mem_we_reg;
    logic [9:0]       waddr_reg;
    logic [7:0]       wdata_reg;
    logic             last_wr_reg;
    logic             done_reg;

    logic             proc;
    logic             restart;
    logic [CW-1:0]    cx, cy;
    logic [CW-1:0]    rel_x, rel_y;
    logic             in_win;
    logic [BXW-1:0]   bx, by;
    logic             blk_end;
    logic [ACC_W-1:0] acc_sel;
    logic [ACC_W-1:0] sum;
    logic             hit;
    logic             flush;
    logic [9:0]       blk_addr;
    logic             final_wr;
    logic [7:0]       avg;
    logic [7:0]       wdata_next;
    logic [OUT_DIM-1:0] col_hit;
    logic             unused_sum_bits;

    // A pixel is consumed in CAPTURE, or in ARM when it is the frame-start pixel.
    assign proc    = pix_vld && ((state_reg == CAPTURE) || ((state_reg == ARM) && pix_sof));
    assign restart = proc && pix_sof;

    // A start-of-frame pixel is always treated as (0,0) regardless of the counters.
    assign cx    = pix_sof ? '0 : x_reg;
    assign cy    = pix_sof ? '0 : y_reg;
    assign rel_x = cx - X_OFF_C;
    assign rel_y = cy - Y_OFF_C;

    assign in_win  = (cx >= X_OFF_C) && (rel_x < WIN_C) && (cy >= Y_OFF_C) && (rel_y < WIN_C);
    assign bx      = rel_x[LB +: BXW];
    assign by      = rel_y[LB +: BXW];
    assign blk_end = (&rel_x[LB-1:0]) && (&rel_y[LB-1:0]);

    // Accumulators are logically zero on a restart pixel even though they clear at the edge.
    assign acc_sel  = (in_win && !pix_sof) ? acc_reg[bx] : '0;
    assign sum      = acc_sel + ACC_W'(pix_data);
    assign hit      = proc && in_win;
    assign flush    = hit && blk_end;
    assign blk_addr = 10'(by) * DIM_C + 10'(bx);
    assign final_wr = flush && (blk_addr == LAST_C);

    assign avg             = sum[ACC_W-1 -: 8];
    assign wdata_next      = (INVERT != 0) ? ~avg : avg;
    assign unused_sum_bits = ^sum[ACC_W-9:0];

    genvar gi;
    generate
        for (gi = 0; gi < OUT_DIM; gi++) begin : g_col
            assign col_hit[gi] = hit && (bx == BXW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = ARM;
            end
            ARM: begin
                if (pix_vld && pix_sof) state_next = final_wr ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                if (final_wr) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // busy stays up through the final write cycle so it drops together with done.
    always_comb begin
        busy      = (state_reg != IDLE) || last_wr_reg;
        done      = done_reg;
        mem_we    = mem_we_reg;
        mem_waddr = waddr_reg;
        mem_wdata = wdata_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (proc) begin
            if (cx == X_LAST_C) begin
                x_reg <= '0;
                y_reg <= cy + CW'(1);
            end else begin
                x_reg <= cx + CW'(1);
                y_reg <= cy;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DIM; i++) acc_reg[i] <= '0;
        end else begin
            for (int i = 0; i < OUT_DIM; i++) begin
                if (col_hit[i]) begin
                    acc_reg[i] <= flush ? '0 : sum;
                end else if (restart) begin
                    acc_reg[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_reg  <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            last_wr_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            mem_we_reg  <= flush;
            last_wr_reg <= final_wr;
            done_reg    <= last_wr_reg;
            if (flush) begin
                waddr_reg <= blk_addr;
                wdata_reg <= wdata_next;
            end
        end
    end

endmodule

// File: tb/tb_image_capture_writer.sv
// Directed bench for image_capture_writer on a scaled 64x60 stream (BLK=2, 28x28 output),
// with a second INVERT=1 instance sharing the same stimulus.
module tb_image_capture_writer;

    localparam int IMG_W = 64;
    localparam int IMG_H = 60;
    localparam int X_OFF = 4;
    localparam int Y_OFF = 2;
    localparam int BLK   = 2;
    localparam int D     = 28;
    localparam int NW    = D * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pix_vld = 1'b0;
    logic       pix_sof = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic       mem_we, mem_we_i;
    logic [9:0] mem_waddr, mem_waddr_i;
    logic [7:0] mem_wdata, mem_wdata_i;
    logic       busy, busy_i;
    logic       done, done_i;

    image_capture_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
        .BLK(BLK), .OUT_DIM(D), .INVERT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_vld(pix_vld), .pix_sof(pix_sof),
        .pix_data(pix_data), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done)
    );

    image_capture_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
        .BLK(BLK), .OUT_DIM(D), .INVERT(1)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_vld(pix_vld), .pix_sof(pix_sof),
        .pix_data(pix_data), .mem_we(mem_we_i), .mem_waddr(mem_waddr_i), .mem_wdata(mem_wdata_i),
        .busy(busy_i), .done(done_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_mem [NW];
    int  exp_addr = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = -2;
    int  last_wr_cyc = -1;
    int  inv_addr = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    bit  inv_en = 1'b0;
    bit  drv_flag = 1'b0;
    bit  acc_flag = 1'b0;

    // acc_flag: "the pixel accepted at this edge closes a block", so a write must follow.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        acc_flag <= drv_flag;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("we_timing", mem_we, acc_flag);
            if (mem_we) begin
                check("waddr", mem_waddr, exp_addr);
                check("wdata", mem_wdata, exp_mem[exp_addr % NW]);
                if (mem_waddr == 10'(NW - 1)) last_wr_cyc = cyc;
                exp_addr++;
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
        end
        if (inv_en && mem_we_i) begin
            check("inv_waddr", mem_waddr_i, inv_addr);
            check("inv_wdata", mem_wdata_i, 8'h7F);
            inv_addr++;
        end
    end

    function automatic bit in_window(input int x, input int y);
        return (x >= X_OFF) && (x < X_OFF + BLK * D) && (y >= Y_OFF) && (y < Y_OFF + BLK * D);
    endfunction

    function automatic bit blk_last(input int x, input int y);
        return in_window(x, y) && ((x - X_OFF) % BLK == BLK - 1) && ((y - Y_OFF) % BLK == BLK - 1);
    endfunction

    // mode 0: constant c; mode 1: 0x00 inside / 0xFF outside; mode 2: bx*9 inside.
    function automatic logic [7:0] pix_val(input int mode, input int x, input int y, input logic [7:0] c);
        if (mode == 0) return c;
        if (mode == 1) return in_window(x, y) ? 8'h00 : 8'hFF;
        return in_window(x, y) ? 8'(((x - X_OFF) / BLK) * 9) : 8'h55;
    endfunction

    task automatic idle(input int n);
        pix_vld  = 1'b0;
        pix_sof  = 1'b0;
        start    = 1'b0;
        drv_flag = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic fill_exp(input int mode, input logic [7:0] c);
        for (int a = 0; a < NW; a++)
            exp_mem[a] = (mode == 0) ? c : ((mode == 1) ? 8'h00 : 8'((a % D) * 9));
    endtask

    // Streams one frame; stops before pixel index stop_idx (-1: whole frame).
    task automatic send_frame(input int mode, input logic [7:0] c, input bit gaps,
                              input bit cap, input int stop_idx, input int start_idx);
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                if (y * IMG_W + x == stop_idx) return;
                if (gaps) begin
                    repeat ($urandom_range(2, 0)) begin
                        pix_vld  = 1'b0;
                        pix_sof  = 1'($urandom_range(1, 0));
                        pix_data = 8'($urandom);
                        start    = 1'b0;
                        drv_flag = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                pix_vld  = 1'b1;
                pix_sof  = (x == 0) && (y == 0);
                pix_data = pix_val(mode, x, y, c);
                start    = (y * IMG_W + x == start_idx);
                drv_flag = cap && blk_last(x, y);
                @(posedge clk);
                #1;
            end
        end
        idle(1);
    endtask

    task automatic run_full(input string name, input int mode, input logic [7:0] c, input bit gaps);
        fill_exp(mode, c);
        exp_addr    = 0;
        wr_cnt      = 0;
        done_cnt    = 0;
        last_wr_cyc = -1;
        done_cyc    = -2;
        pulse_start();
        check({name, "_busy_arm"}, busy, 1);
        send_frame(mode, c, gaps, 1'b1, -1, -1);
        idle(4);
        check({name, "_wr_count"}, wr_cnt, NW);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_done_latency"}, done_cyc - last_wr_cyc, 1);
        check({name, "_busy_end"}, busy, 0);
        $display("%s: %0d writes, %0d done pulses", name, wr_cnt, done_cnt);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", mem_we, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_inv_busy", busy_i, 0);
        rst_n = 1'b1;
        idle(2);
        mon_en = 1'b1;

        run_full("T1_const80", 0, 8'h80, 1'b0);
        run_full("T2_crop", 1, 8'h00, 1'b0);
        run_full("T3_gradient", 2, 8'h00, 1'b0);
        run_full("T4_gradient_gaps", 2, 8'h00, 1'b1);

        // T5: 0xFF partial frame aborted mid-line by a fresh 0x40 frame; start during CAPTURE.
        fill_exp(0, 8'hFF);
        exp_addr = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        pulse_start();
        send_frame(0, 8'hFF, 1'b0, 1'b1, 21 * IMG_W + 30, 5 * IMG_W + 3);
        idle(2);
        check("T5_partial_writes", wr_cnt, 9 * D + 13);
        check("T5_busy_mid", busy, 1);
        fill_exp(0, 8'h40);
        exp_addr = 0;
        wr_cnt   = 0;
        send_frame(0, 8'h40, 1'b0, 1'b1, -1, -1);
        idle(4);
        check("T5_wr_count", wr_cnt, NW);
        check("T5_done_count", done_cnt, 1);
        check("T5_busy_end", busy, 0);
        $display("T5_resync: %0d writes after restart, %0d done pulses", wr_cnt, done_cnt);

        // T6a: async reset right after a block write is issued.
        fill_exp(0, 8'h80);
        exp_addr = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        pulse_start();
        send_frame(0, 8'h80, 1'b0, 1'b1, 31 * IMG_W + 6, -1);
        pix_vld  = 1'b0;
        drv_flag = 1'b0;
        check("T6_writes_before_rst", wr_cnt, 14 * D);
        check("T6_we_before_rst", mem_we, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("T6_rst_we", mem_we, 0);
        check("T6_rst_busy", busy, 0);
        check("T6_rst_done", done, 0);
        check("T6_rst_waddr", mem_waddr, 0);
        #2;
        rst_n = 1'b1;
        idle(2);
        mon_en = 1'b1;
        check("T6_no_done_after_rst", done_cnt, 0);

        // T6b: a full stream with no start must produce nothing.
        wr_cnt = 0;
        send_frame(0, 8'h80, 1'b0, 1'b0, -1, -1);
        idle(4);
        check("T6_nostart_writes", wr_cnt, 0);
        check("T6_nostart_done", done_cnt, 0);
        check("T6_nostart_busy", busy, 0);
        $display("T6_reset_nostart: %0d writes, %0d done pulses", wr_cnt, done_cnt);

        // T6c: INVERT instance on a 0x80 frame.
        inv_en   = 1'b1;
        inv_addr = 0;
        run_full("T6_invert_main", 0, 8'h80, 1'b0);
        inv_en = 1'b0;
        check("T6_inv_wr_count", inv_addr, NW);
        check("T6_inv_busy_end", busy_i, 0);
        $display("T6_invert: %0d inverted writes", inv_addr);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
